// File: rtl/branch_resolve_controller_if.sv
// Branch request / redirect bundle between decode-issue, fetch and the
// branch resolve controller. The controller uses the slave modport; the
// environment (decode/issue plus fetch) uses the master modport.
interface branch_resolve_controller_if #(
  parameter int ADDR_WIDTH             = 32,
  parameter int BRANCH_CONDITION_WIDTH = 4
);
  logic                              branch_valid;
  logic                              branch_ready;
  logic [BRANCH_CONDITION_WIDTH-1:0] branch_condition;
  logic [ADDR_WIDTH-1:0]             branch_target;
  logic [ADDR_WIDTH-1:0]             branch_fallthrough;
  logic                              redirect_valid;
  logic                              redirect_ready;
  logic [ADDR_WIDTH-1:0]             redirect_pc;
  logic                              redirect_taken;
  logic                              flush;

  modport master (
    output branch_valid, branch_condition, branch_target, branch_fallthrough, redirect_ready,
    input  branch_ready, redirect_valid, redirect_pc, redirect_taken, flush
  );

  modport slave (
    input  branch_valid, branch_condition, branch_target, branch_fallthrough, redirect_ready,
    output branch_ready, redirect_valid, redirect_pc, redirect_taken, flush
  );
endinterface

// File: rtl/branch_resolve_controller.sv
// Branch resolve controller: owns the NZCV flag register, stalls accepted
// branches while a flag-writing op is in flight, evaluates the condition code
// and hands a redirect to fetch over a valid/ready handshake.
// Optional build macro FLAG_FORWARD_EN: when defined, a flag write arriving in
// RESOLVE is bypassed into the evaluation; otherwise RESOLVE waits one cycle
// and evaluates the updated register.
module branch_resolve_controller #(
  parameter int ADDR_WIDTH             = 32,
  parameter int BRANCH_CONDITION_WIDTH = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       flag_write_en_i,
  input  logic [3:0] flag_in_i,
  input  logic       flag_pending_i,
  output logic       busy_o,
  output logic [3:0] flags_out_o,
  branch_resolve_controller_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FLAGS = 2'd1,
    RESOLVE    = 2'd2,
    REDIRECT   = 2'd3
  } state_t;

  state_t                            state_q;
  logic [3:0]                        flags_q;
  logic [BRANCH_CONDITION_WIDTH-1:0] cond_q;
  logic [ADDR_WIDTH-1:0]             target_q;
  logic [ADDR_WIDTH-1:0]             fallthrough_q;
  logic [ADDR_WIDTH-1:0]             redirect_pc_q;
  logic                              redirect_taken_q;
  logic                              redirect_valid_q;
  logic                              flush_q;
  logic                              branch_ready_q;
  logic                              busy_q;

  logic [3:0]                        eval_flags_d;
  logic                              resolve_hold_d;
  logic                              take_d;
  logic [ADDR_WIDTH-1:0]             redirect_pc_d;

  // Condition table over {N,Z,C,V}; codes above 14 are never taken.
  function automatic logic cond_take(input logic [BRANCH_CONDITION_WIDTH-1:0] c,
                                     input logic [3:0] f);
    logic n, z, cy, v, t;
    {n, z, cy, v} = f;
    t = 1'b0;
    if (c <= BRANCH_CONDITION_WIDTH'(14)) begin
      case (c[3:0])
        4'd0:    t = z;
        4'd1:    t = !z;
        4'd2:    t = cy;
        4'd3:    t = !cy;
        4'd4:    t = n;
        4'd5:    t = !n;
        4'd6:    t = v;
        4'd7:    t = !v;
        4'd8:    t = cy & !z;
        4'd9:    t = !cy | z;
        4'd10:   t = (n == v);
        4'd11:   t = (n != v);
        4'd12:   t = !z & (n == v);
        4'd13:   t = z | (n != v);
        4'd14:   t = 1'b1;
        default: t = 1'b0;
      endcase
    end
    return t;
  endfunction

  // Pick the flags the RESOLVE evaluation sees and whether RESOLVE must wait a cycle.
  always_comb begin
    eval_flags_d   = flags_q;
    resolve_hold_d = 1'b0;
`ifdef FLAG_FORWARD_EN
    if (flag_write_en_i) eval_flags_d = flag_in_i;
`else
    resolve_hold_d = flag_write_en_i;
`endif
    take_d        = cond_take(cond_q, eval_flags_d);
    redirect_pc_d = take_d ? target_q : fallthrough_q;
  end

  // Flag register plus the branch sequencing FSM with registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= IDLE;
      flags_q          <= 4'b0000;
      cond_q           <= '0;
      target_q         <= '0;
      fallthrough_q    <= '0;
      redirect_pc_q    <= '0;
      redirect_taken_q <= 1'b0;
      redirect_valid_q <= 1'b0;
      flush_q          <= 1'b0;
      branch_ready_q   <= 1'b1;
      busy_q           <= 1'b0;
    end else begin
      if (flag_write_en_i) flags_q <= flag_in_i;
      flush_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.branch_valid) begin
            cond_q         <= bus.branch_condition;
            target_q       <= bus.branch_target;
            fallthrough_q  <= bus.branch_fallthrough;
            branch_ready_q <= 1'b0;
            busy_q         <= 1'b1;
            state_q        <= flag_pending_i ? WAIT_FLAGS : RESOLVE;
          end
        end
        WAIT_FLAGS: begin
          if (!flag_pending_i) state_q <= RESOLVE;
        end
        RESOLVE: begin
          if (!resolve_hold_d) begin
            redirect_pc_q    <= redirect_pc_d;
            redirect_taken_q <= take_d;
            redirect_valid_q <= 1'b1;
            flush_q          <= take_d;
            state_q          <= REDIRECT;
          end
        end
        REDIRECT: begin
          if (bus.redirect_ready) begin
            redirect_valid_q <= 1'b0;
            branch_ready_q   <= 1'b1;
            busy_q           <= 1'b0;
            state_q          <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.branch_ready   = branch_ready_q;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.redirect_taken = redirect_taken_q;
  assign bus.flush          = flush_q;
  assign busy_o             = busy_q;
  assign flags_out_o        = flags_q;

endmodule

// File: tb/tb_branch_resolve_controller.sv
// Self-checking bench for branch_resolve_controller: directed scenarios then
// randomized branches, checked against a condition/latency model.
// Honours FLAG_FORWARD_EN the same way the design does.
module tb_branch_resolve_controller;
  localparam int AW = 32;
  localparam int CW = 4;
`ifdef FLAG_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       flag_write_en = 1'b0;
  logic [3:0] flag_in = 4'h0;
  logic       flag_pending = 1'b0;
  logic       busy;
  logic [3:0] flags_out;

  branch_resolve_controller_if #(.ADDR_WIDTH(AW), .BRANCH_CONDITION_WIDTH(CW)) bus ();

  branch_resolve_controller #(.ADDR_WIDTH(AW), .BRANCH_CONDITION_WIDTH(CW)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .flag_write_en_i (flag_write_en),
    .flag_in_i       (flag_in),
    .flag_pending_i  (flag_pending),
    .busy_o          (busy),
    .flags_out_o     (flags_out),
    .bus             (bus)
  );

  always #5 clock = ~clock;

  int         checks = 0;
  int         errors = 0;
  int         tx = 0;
  logic [3:0] flags_m = 4'h0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Conditions come in pairs: odd code = negation of the even predicate before it.
  function automatic bit ref_take(input int code, input logic [3:0] f);
    bit n, z, c, v;
    bit base [7];
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    base[0] = z;
    base[1] = c;
    base[2] = n;
    base[3] = v;
    base[4] = c && !z;
    base[5] = (n == v);
    base[6] = !z && (n == v);
    if (code == 14) return 1'b1;
    if (code >= 15) return 1'b0;
    return base[code / 2] ^ (code % 2 == 1);
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_flags(input logic [3:0] f);
    flag_write_en = 1'b1;
    flag_in       = f;
    flags_m       = f;
    step();
    flag_write_en = 1'b0;
    chk("set_flags", flags_out, flags_m);
  endtask

  // One branch from IDLE through redirect handshake.
  // s: cycles flag_pending is high from the accept cycle; wr_stall writes stall_f in
  // the last pending cycle; wr_res writes res_f in the RESOLVE cycle; d: ready delay.
  task automatic run_branch(input int cond, input logic [31:0] tgt, input logic [31:0] fall,
                            input int s, input bit wr_stall, input logic [3:0] stall_f,
                            input bit wr_res, input logic [3:0] res_f,
                            input int d, input bit rnd);
    int          res;
    int          lat;
    bit          exp_taken;
    logic [31:0] exp_pc;
    res = (s == 0) ? 1 : s + 1;
    lat = res + 1 + ((wr_res && !FWD) ? 1 : 0);
    exp_taken = 1'b0;
    chk("idle_ready", bus.branch_ready, 1);
    chk("idle_busy", busy, 0);
    for (int c = 0; c < lat; c++) begin
      if (c == 0) begin
        bus.branch_valid       = 1'b1;
        bus.branch_condition   = cond[3:0];
        bus.branch_target      = tgt;
        bus.branch_fallthrough = fall;
      end else begin
        bus.branch_valid       = rnd ? 1'($urandom_range(1)) : 1'b0;
        bus.branch_condition   = 4'($urandom);
        bus.branch_target      = $urandom;
        bus.branch_fallthrough = $urandom;
      end
      flag_pending  = (c < s);
      flag_write_en = 1'b0;
      if (c == res && wr_res) begin
        flag_write_en = 1'b1;
        flag_in       = res_f;
      end else if (s > 0 && c == s - 1 && wr_stall) begin
        flag_write_en = 1'b1;
        flag_in       = stall_f;
      end else if (rnd && c < res && $urandom_range(2) == 0) begin
        flag_write_en = 1'b1;
        flag_in       = 4'($urandom);
      end
      if (flag_write_en) flags_m = flag_in;
      if (c == res) exp_taken = ref_take(cond, flags_m);
      bus.redirect_ready = rnd ? 1'($urandom_range(1)) : 1'b0;
      step();
      chk("flags", flags_out, flags_m);
      if (c < lat - 1) begin
        chk("early_valid", bus.redirect_valid, 0);
        chk("busy", busy, 1);
        chk("busy_ready", bus.branch_ready, 0);
      end
    end
    flag_write_en = 1'b0;
    flag_pending  = 1'b0;
    exp_pc = exp_taken ? tgt : fall;
    chk("redir_valid", bus.redirect_valid, 1);
    chk("redir_pc", bus.redirect_pc, exp_pc);
    chk("redir_taken", bus.redirect_taken, exp_taken);
    chk("flush_first", bus.flush, exp_taken);
    chk("redir_ready", bus.branch_ready, 0);
    for (int k = 0; k < d; k++) begin
      bus.redirect_ready = 1'b0;
      bus.branch_valid   = rnd ? 1'($urandom_range(1)) : 1'b0;
      flag_write_en      = rnd ? 1'($urandom_range(1)) : 1'b0;
      flag_in            = 4'($urandom);
      if (flag_write_en) flags_m = flag_in;
      step();
      chk("hold_valid", bus.redirect_valid, 1);
      chk("hold_pc", bus.redirect_pc, exp_pc);
      chk("hold_taken", bus.redirect_taken, exp_taken);
      chk("hold_flush", bus.flush, 0);
      chk("hold_ready", bus.branch_ready, 0);
      chk("hold_flags", flags_out, flags_m);
    end
    bus.redirect_ready = 1'b1;
    bus.branch_valid   = 1'b0;
    flag_write_en      = 1'b0;
    step();
    bus.redirect_ready = 1'b0;
    chk("done_valid", bus.redirect_valid, 0);
    chk("done_busy", busy, 0);
    chk("done_ready", bus.branch_ready, 1);
    chk("done_flush", bus.flush, 0);
    chk("done_flags", flags_out, flags_m);
    $display("tx %0d cond=%0d stall=%0d wr_res=%0d delay=%0d lat=%0d taken=%0d pc=%08h",
             tx, cond, s, wr_res, d, lat, exp_taken, exp_pc);
    tx++;
  endtask

  initial begin
    bus.branch_valid       = 1'b0;
    bus.branch_condition   = '0;
    bus.branch_target      = '0;
    bus.branch_fallthrough = '0;
    bus.redirect_ready     = 1'b0;

    // Reset state while held in reset
    #1;
    chk("rst_valid", bus.redirect_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flags", flags_out, 0);
    chk("rst_pc", bus.redirect_pc, 0);
    chk("rst_flush", bus.flush, 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    step();
    chk("rst_ready", bus.branch_ready, 1);

    // EQ with Z=1, no stall: taken to 0x100 at latency 2
    set_flags(4'b0100);
    run_branch(0, 32'h100, 32'h204, 0, 1'b0, 4'h0, 1'b0, 4'h0, 0, 1'b0);

    // GT with N=1,V=0: not taken; code 15 never taken
    set_flags(4'b1000);
    run_branch(12, 32'h300, 32'h404, 0, 1'b0, 4'h0, 1'b0, 4'h0, 0, 1'b0);
    set_flags(4'b1111);
    run_branch(15, 32'h500, 32'h604, 0, 1'b0, 4'h0, 1'b0, 4'h0, 0, 1'b0);

    // Three stall cycles, Z cleared during stall: NE taken at latency 5
    set_flags(4'b0100);
    run_branch(1, 32'h700, 32'h804, 3, 1'b1, 4'b0000, 1'b0, 4'h0, 0, 1'b0);

    // Fetch back-pressure for 4 cycles
    run_branch(14, 32'h900, 32'hA04, 0, 1'b0, 4'h0, 1'b0, 4'h0, 4, 1'b0);

    // Flag write during RESOLVE: C 0 -> 1, CS taken
    set_flags(4'b0000);
    run_branch(2, 32'hB00, 32'hC04, 0, 1'b0, 4'h0, 1'b1, 4'b0010, 0, 1'b0);

    // Reset while a redirect is being presented
    set_flags(4'b1010);
    bus.branch_valid       = 1'b1;
    bus.branch_condition   = 4'd14;
    bus.branch_target      = 32'hD00;
    bus.branch_fallthrough = 32'hE04;
    step();
    bus.branch_valid = 1'b0;
    step();
    step();
    chk("pre_rst_valid", bus.redirect_valid, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_valid", bus.redirect_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_flags", flags_out, 0);
    chk("midrst_taken", bus.redirect_taken, 0);
    chk("midrst_pc", bus.redirect_pc, 0);
    flags_m = 4'h0;
    @(negedge clock);
    reset_n = 1'b1;
    step();
    chk("post_rst_ready", bus.branch_ready, 1);

    // Randomized branches
    for (int i = 0; i < 40; i++) begin
      run_branch(int'($urandom_range(15)), $urandom, $urandom,
                 int'($urandom_range(3)), 1'($urandom_range(1)), 4'($urandom),
                 1'($urandom_range(1)), 4'($urandom),
                 int'($urandom_range(3)), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
